// File: rtl/keccak_absorb_packer.sv
// keccak_absorb_packer
//   Absorb-side front end for the Keccak core. Takes a message as IW-bit
//   words, applies SHA3/SHAKE domain separation and pad10*1, and emits
//   rate-sized blocks of 64-bit lanes with block and message delimiters.
//
//   State table
//   state | meaning
//   IDLE  | waiting for i_start; latches mode and length
//   LOAD  | requesting the next message word (o_data_ready=1)
//   EMIT  | emitting lanes out of the buffered word
//   PAD   | emitting zero-data lanes carrying padding until msg_last
//
// Ports
//   i_clk, i_rstn                 clock, async active-low reset
//   i_start, i_mode, i_len        message start, hash mode, byte length
//   i_data, i_data_valid          input word stream
//   o_data_ready                  word accepted on valid&ready
//   o_lane, o_lane_idx            padded lane and its index within the block
//   o_lane_valid, i_lane_ready    lane handshake
//   o_block_last, o_msg_last      lane delimiters
//   o_busy                        high outside IDLE
module keccak_absorb_packer #(
  parameter int IW    = 64,
  parameter int LEN_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [LEN_W-1:0] i_len,
  input  logic [IW-1:0]    i_data,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  output logic [63:0]      o_lane,
  output logic [4:0]       o_lane_idx,
  output logic             o_lane_valid,
  input  logic             i_lane_ready,
  output logic             o_block_last,
  output logic             o_msg_last,
  output logic             o_busy
);

  localparam int NLW   = IW / 64;
  localparam int PW    = (NLW > 1) ? $clog2(NLW) : 1;
  localparam int POS_W = LEN_W + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_PAD  = 2'd3;

  logic [1:0]       state;
  logic [4:0]       rate;
  logic [7:0]       dom;
  logic [LEN_W-1:0] len;
  logic [IW-1:0]    word_buf;
  logic [PW-1:0]    ptr;
  logic [POS_W-1:0] pos;
  // Byte offset one past the end of the current block; the final block is
  // the one whose end lies beyond L.
  logic [POS_W-1:0] blk_end;
  logic [4:0]       idx;

  logic [4:0]       start_rate;
  logic [7:0]       start_dom;
  logic [POS_W-1:0] len_x;
  logic [POS_W-1:0] pos_nxt;
  logic [POS_W-1:0] rate_bytes;
  logic [PW:0]      ptr_nxt;
  logic             lane_vld;
  logic             blk_last;
  logic             fin_blk;
  logic             msg_last;
  logic             lane_hs;
  logic [63:0]      data_lane;
  logic [63:0]      lane_val;

  always_comb begin
    start_rate = 5'd17;
    start_dom  = 8'h06;
    case (i_mode)
      2'd0: begin start_rate = 5'd17; start_dom = 8'h06; end
      2'd1: begin start_rate = 5'd9;  start_dom = 8'h06; end
      2'd2: begin start_rate = 5'd21; start_dom = 8'h1F; end
      default: begin start_rate = 5'd17; start_dom = 8'h1F; end
    endcase
  end

  assign len_x      = POS_W'(len);
  assign pos_nxt    = pos + POS_W'(8);
  assign rate_bytes = POS_W'({rate, 3'b000});
  assign ptr_nxt    = {1'b0, ptr} + 1'b1;

  assign lane_vld = (state == ST_EMIT) || (state == ST_PAD);
  assign blk_last = (idx == rate - 5'd1);
  assign fin_blk  = (len_x < blk_end);
  assign msg_last = lane_vld && blk_last && fin_blk;
  assign lane_hs  = lane_vld && i_lane_ready;

  always_comb begin
    data_lane = '0;
    for (int j = 0; j < NLW; j++) begin
      if (ptr == PW'(j)) data_lane = word_buf[j*64 +: 64];
    end
  end

  // Bytes at or past L never come from the word (the tail of the final
  // word is don't-care); the domain byte lands exactly at L and the
  // closing 0x80 XORs into byte 7 of the final lane.
  always_comb begin
    lane_val = '0;
    for (int b = 0; b < 8; b++) begin
      if ((state == ST_EMIT) && ((pos + POS_W'(b)) < len_x))
        lane_val[8*b +: 8] = data_lane[8*b +: 8];
      if ((pos + POS_W'(b)) == len_x)
        lane_val[8*b +: 8] = lane_val[8*b +: 8] ^ dom;
    end
    if (msg_last) lane_val[63:56] = lane_val[63:56] ^ 8'h80;
  end

  assign o_data_ready = (state == ST_LOAD);
  assign o_lane_valid = lane_vld;
  assign o_lane       = lane_vld ? lane_val : 64'd0;
  assign o_lane_idx   = idx;
  assign o_block_last = lane_vld && blk_last;
  assign o_msg_last   = msg_last;
  assign o_busy       = (state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= ST_IDLE;
      rate     <= 5'd17;
      dom      <= 8'h06;
      len      <= '0;
      word_buf <= '0;
      ptr      <= '0;
      pos      <= '0;
      blk_end  <= '0;
      idx      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            rate    <= start_rate;
            dom     <= start_dom;
            len     <= i_len;
            pos     <= '0;
            idx     <= '0;
            blk_end <= POS_W'({start_rate, 3'b000});
            state   <= (i_len != '0) ? ST_LOAD : ST_PAD;
          end
        end
        ST_LOAD: begin
          if (i_data_valid) begin
            word_buf <= i_data;
            ptr      <= '0;
            state    <= ST_EMIT;
          end
        end
        default: begin
          if (lane_hs) begin
            pos <= pos_nxt;
            if (blk_last) begin
              idx     <= '0;
              blk_end <= blk_end + rate_bytes;
            end else begin
              idx <= idx + 5'd1;
            end
            if (msg_last) begin
              state <= ST_IDLE;
            end else if (state == ST_EMIT) begin
              ptr <= ptr_nxt[PW-1:0];
              if ((ptr_nxt == (PW+1)'(NLW)) || (pos_nxt >= len_x))
                state <= (pos_nxt < len_x) ? ST_LOAD : ST_PAD;
            end
          end
        end
      endcase
    end
  end

endmodule
